// File: rtl/project2_pkg.sv
// Shared stopwatch definitions: timestamp packing
// and the lap capture FSM state encoding.
package project2_pkg;

   localparam int UNIT_W = 7;
   localparam int UNITS  = 4;
   localparam int TS_W   = UNIT_W * UNITS;

   localparam int M_SEC  = 0;
   localparam int SECOND = 1;
   localparam int MINUTE = 2;
   localparam int HOUR   = 3;

   typedef enum logic {
      IDLE,
      WAIT_TS
   } cap_state_t;

endpackage

// File: rtl/lap_ram.sv
// Lap storage: DEPTH x TS_W, synchronous write, registered read.
// Ports: clock, reset_n, we/wr_addr/wr_data, rd_addr, rd_zero, rd_data.
module lap_ram #(
   parameter int DEPTH = 8,
   parameter int TS_W  = 28,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            we,
   input  logic [AW-1:0]   wr_addr,
   input  logic [TS_W-1:0] wr_data,
   input  logic [AW-1:0]   rd_addr,
   input  logic            rd_zero,
   output logic [TS_W-1:0] rd_data
);

   logic [TS_W-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we)
         mem[wr_addr] <= wr_data;
   end

   // Only the read register is reset; the array is don't-care.
   always_ff @(posedge clock) begin
      if (!reset_n || rd_zero)
         rd_data <= '0;
      else
         rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/lap_store.sv
// Lap-time capture buffer with newest-first playback.
// Ports: clock, reset_n, timestamp, timer_busy, capture, clear,
//        recall_next, recall_exit, lap_timestamp, lap_index,
//        lap_count, recall_active, busy, full.
module lap_store
   import project2_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int TS_W  = project2_pkg::TS_W,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic [TS_W-1:0] timestamp,
   input  logic            timer_busy,
   input  logic            capture,
   input  logic            clear,
   input  logic            recall_next,
   input  logic            recall_exit,
   output logic [TS_W-1:0] lap_timestamp,
   output logic [AW-1:0]   lap_index,
   output logic [CW-1:0]   lap_count,
   output logic            recall_active,
   output logic            busy,
   output logic            full
);

   cap_state_t      state;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_addr;
   logic [CW-1:0]   cnt_inc;
   logic            wr_en;

   assign wr_en = reset_n && !clear &&
                  (state == WAIT_TS) && !timer_busy;

   assign cnt_inc = full ? lap_count : lap_count + CW'(1);

   // Newest entry sits just behind the write pointer.
   assign rd_addr = wr_ptr - AW'(1) - lap_index;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state         <= IDLE;
         busy          <= 1'b0;
         wr_ptr        <= '0;
         lap_count     <= '0;
         full          <= 1'b0;
         recall_active <= 1'b0;
         lap_index     <= '0;
      end else if (clear) begin
         state         <= IDLE;
         busy          <= 1'b0;
         wr_ptr        <= '0;
         lap_count     <= '0;
         full          <= 1'b0;
         recall_active <= 1'b0;
         lap_index     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (capture) begin
                  state <= WAIT_TS;
                  busy  <= 1'b1;
               end
            end
            WAIT_TS: begin
               if (!timer_busy) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  wr_ptr    <= wr_ptr + 1'b1;
                  lap_count <= cnt_inc;
                  full      <= (cnt_inc == CW'(DEPTH));
                  if (recall_active && CW'(lap_index) >= cnt_inc)
                     lap_index <= '0;
               end
            end
            default: state <= IDLE;
         endcase

         if (recall_exit) begin
            recall_active <= 1'b0;
            lap_index     <= '0;
         end else if (recall_next && !wr_en) begin
            if (!recall_active) begin
               if (lap_count != '0) begin
                  recall_active <= 1'b1;
                  lap_index     <= '0;
               end
            end else if (CW'(lap_index) == lap_count - CW'(1)) begin
               lap_index <= '0;
            end else begin
               lap_index <= lap_index + 1'b1;
            end
         end
      end
   end

   lap_ram #(
      .DEPTH (DEPTH),
      .TS_W  (TS_W)
   ) u_ram (
      .clock   (clock),
      .reset_n (reset_n),
      .we      (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (timestamp),
      .rd_addr (rd_addr),
      .rd_zero (lap_count == '0),
      .rd_data (lap_timestamp)
   );

endmodule

// File: tb/tb_lap_store.sv
// Self-checking bench for lap_store against a queue-based lap model.
// Ports of the DUT are all driven/observed here.
module tb_lap_store;

   localparam int DEPTH = 8;
   localparam int TS_W  = 28;

   logic            clock = 1'b0;
   logic            reset_n = 1'b0;
   logic [TS_W-1:0] timestamp = '0;
   logic            timer_busy = 1'b0;
   logic            capture = 1'b0;
   logic            clear = 1'b0;
   logic            recall_next = 1'b0;
   logic            recall_exit = 1'b0;
   logic [TS_W-1:0] lap_timestamp;
   logic [2:0]      lap_index;
   logic [3:0]      lap_count;
   logic            recall_active;
   logic            busy;
   logic            full;

   always #5 clock = ~clock;

   lap_store #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .timestamp     (timestamp),
      .timer_busy    (timer_busy),
      .capture       (capture),
      .clear         (clear),
      .recall_next   (recall_next),
      .recall_exit   (recall_exit),
      .lap_timestamp (lap_timestamp),
      .lap_index     (lap_index),
      .lap_count     (lap_count),
      .recall_active (recall_active),
      .busy          (busy),
      .full          (full)
   );

   int checks = 0;
   int errors = 0;

   // Model: laps newest-first, plus pending/recall state.
   logic [TS_W-1:0] q[$];
   bit              pend;
   bit              act;
   int              idx;
   logic [TS_W-1:0] ets;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("busy", 32'(busy), 32'(pend));
      chk("lap_count", 32'(lap_count), 32'(q.size()));
      chk("full", 32'(full), 32'(q.size() == DEPTH));
      chk("recall_active", 32'(recall_active), 32'(act));
      chk("lap_index", 32'(lap_index), 32'(idx));
      chk("lap_timestamp", 32'(lap_timestamp), 32'(ets));
   endtask

   task automatic step(bit cap, bit clr, bit nxt, bit ext,
                       bit tbz, logic [TS_W-1:0] ts);
      bit wr;
      @(negedge clock);
      capture     = cap;
      clear       = clr;
      recall_next = nxt;
      recall_exit = ext;
      timer_busy  = tbz;
      timestamp   = ts;
      @(posedge clock);
      // Display register loads from the pre-edge lap set.
      ets = (q.size() == 0) ? '0 : q[idx];
      if (clr) begin
         q.delete();
         pend = 0;
         act  = 0;
         idx  = 0;
      end else begin
         wr = pend && !tbz;
         if (wr) begin
            q.push_front(ts);
            if (q.size() > DEPTH) void'(q.pop_back());
            pend = 0;
            if (act && idx > q.size() - 1) idx = 0;
         end else if (cap) begin
            pend = 1;
         end
         if (ext) begin
            act = 0;
            idx = 0;
         end else if (nxt && !wr) begin
            if (!act) begin
               if (q.size() > 0) begin
                  act = 1;
                  idx = 0;
               end
            end else begin
               idx = (idx + 1) % q.size();
            end
         end
      end
      #1;
      check_all();
   endtask

   function automatic logic [TS_W-1:0] rnd_ts();
      return TS_W'($urandom);
   endfunction

   initial begin
      pend = 0;
      act  = 0;
      idx  = 0;
      ets  = '0;

      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check_all();
      reset_n = 1'b1;

      step(0, 0, 1, 0, 0, rnd_ts());
      chk("empty_recall_ignored", 32'(recall_active), 32'd0);

      step(1, 0, 0, 0, 0, rnd_ts());
      chk("busy_after_cap", 32'(busy), 32'd1);
      step(0, 0, 0, 0, 0, 28'h0204_0A05);
      chk("busy_one_cycle", 32'(busy), 32'd0);
      chk("count_one", 32'(lap_count), 32'd1);
      step(0, 0, 0, 0, 0, rnd_ts());
      chk("first_lap", 32'(lap_timestamp), 32'h0204_0A05);

      step(1, 0, 0, 0, 1, rnd_ts());
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 1, rnd_ts());
         chk("busy_stall", 32'(busy), 32'd1);
      end
      step(0, 0, 0, 0, 0, 28'h0AB_CDEF);
      chk("busy_stall_end", 32'(busy), 32'd0);
      step(0, 0, 0, 0, 0, rnd_ts());
      chk("stall_lap", 32'(lap_timestamp), 32'h0AB_CDEF);

      step(0, 1, 0, 0, 0, rnd_ts());
      for (int i = 1; i <= 10; i++) begin
         step(1, 0, 0, 0, 0, rnd_ts());
         step(0, 0, 0, 0, 0, TS_W'(i));
      end
      chk("full_after_10", 32'(full), 32'd1);
      chk("count_sat", 32'(lap_count), 32'd8);

      for (int k = 0; k < 9; k++) begin
         step(0, 0, 1, 0, 0, rnd_ts());
         step(0, 0, 0, 0, 0, rnd_ts());
         chk("recall_idx", 32'(lap_index), 32'(k % 8));
         chk("recall_val", 32'(lap_timestamp), 32'(10 - (k % 8)));
      end

      step(0, 0, 1, 0, 0, rnd_ts());
      step(0, 0, 1, 0, 0, rnd_ts());
      chk("idx_two", 32'(lap_index), 32'd2);
      step(1, 1, 0, 0, 0, rnd_ts());
      chk("clr_count", 32'(lap_count), 32'd0);
      chk("clr_recall", 32'(recall_active), 32'd0);
      step(0, 0, 0, 0, 0, rnd_ts());
      chk("clr_ts", 32'(lap_timestamp), 32'd0);

      step(1, 0, 0, 0, 1, rnd_ts());
      step(0, 1, 0, 0, 1, rnd_ts());
      chk("abort_busy", 32'(busy), 32'd0);
      step(0, 0, 0, 0, 0, rnd_ts());
      chk("abort_count", 32'(lap_count), 32'd0);

      for (int n = 0; n < 800; n++) begin
         step(($urandom_range(0, 99) < 40),
              ($urandom_range(0, 99) < 3),
              ($urandom_range(0, 99) < 35),
              ($urandom_range(0, 99) < 6),
              ($urandom_range(0, 99) < 40),
              rnd_ts());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
